// File: rtl/snake_vga_renderer.sv
// Snake game pixel renderer.
// Classifies each scanned pixel as apple, head, body, wall or empty and
// colours it. A vsync-driven frame counter makes the apple pulse and the
// snake flash on game over. A pause mode dims the picture. The play mode is
// latched only on a vsync rising edge, so a mode change never tears a frame.
// There is a fixed 2-clock pipeline. de/hs/vs go through delay lines of the
// same length, so they stay aligned with vga_rgb.
module snake_vga_renderer #(
    parameter int          H_ACTIVE    = 480,
    parameter int          V_ACTIVE    = 272,
    parameter int          CELL_LOG2   = 4,
    parameter int          GRID_X_W    = 6,
    parameter int          GRID_Y_W    = 5,
    parameter int          BLINK_LOG2  = 4,
    parameter logic [23:0] HEAD_COLOR  = 24'h0000FF,
    parameter logic [23:0] BODY_COLOR  = 24'hFFFF00,
    parameter logic [23:0] WALL_COLOR  = 24'hFF0000,
    parameter logic [23:0] APPLE_COLOR = 24'hFF0000,
    parameter logic [23:0] BG_COLOR    = 24'h000000,
    parameter logic [23:0] OVER_COLOR  = 24'hFFFFFF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [11:0]         x_pos,
    input  logic [11:0]         y_pos,
    input  logic                de_in,
    input  logic                hs_in,
    input  logic                vs_in,
    input  logic [1:0]          snake,
    input  logic [GRID_X_W-1:0] apple_x,
    input  logic [GRID_Y_W-1:0] apple_y,
    input  logic [1:0]          mode,
    output logic [23:0]         vga_rgb,
    output logic                de_out,
    output logic                hs_out,
    output logic                vs_out
);

    localparam logic [1:0]  MODE_PLAY   = 2'b00;
    localparam logic [1:0]  MODE_PAUSE  = 2'b01;
    localparam logic [1:0]  MODE_OVER   = 2'b10;

    localparam logic [1:0]  CODE_HEAD   = 2'b01;
    localparam logic [1:0]  CODE_BODY   = 2'b10;
    localparam logic [1:0]  CODE_WALL   = 2'b11;

    localparam logic [11:0] LP_H_ACTIVE = 12'(H_ACTIVE);
    localparam logic [11:0] LP_V_ACTIVE = 12'(V_ACTIVE);

    // Halve every 8-bit channel. Used for the apple pulse and the pause dim.
    function automatic logic [23:0] f_half(input logic [23:0] c);
        return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
    endfunction

    // Frame-rate state
    logic                  r_vs_prev;
    logic [BLINK_LOG2-1:0] r_frame_cnt;
    logic [1:0]            r_mode_lat;

    // Stage 1 registers
    logic                  r_active_p1;
    logic                  r_apple_p1;
    logic                  r_corner_p1;
    logic [1:0]            r_code_p1;
    logic                  r_de_p1;
    logic                  r_hs_p1;
    logic                  r_vs_p1;

    // Stage 0 combinational classification
    logic [GRID_X_W-1:0]   w_cell_x;
    logic [GRID_Y_W-1:0]   w_cell_y;
    logic                  w_active_p0;
    logic                  w_apple_p0;
    logic                  w_corner_p0;
    logic [1:0]            w_mode_norm;
    logic                  w_vs_rise;

    // Stage 2 colour selection
    logic                  w_phase;
    logic                  w_pause;
    logic                  w_over;
    logic                  w_play;
    logic [23:0]           w_rgb_p1;

    // Cell indices are truncated, so an apple outside the visible grid never matches.
    assign w_cell_x    = GRID_X_W'(x_pos >> CELL_LOG2);
    assign w_cell_y    = GRID_Y_W'(y_pos >> CELL_LOG2);
    assign w_active_p0 = (x_pos < LP_H_ACTIVE) && (y_pos < LP_V_ACTIVE);
    assign w_apple_p0  = (w_cell_x == apple_x) && (w_cell_y == apple_y);
    assign w_corner_p0 = (x_pos[CELL_LOG2-1:0] == '0) && (y_pos[CELL_LOG2-1:0] == '0);

    // The reserved mode code behaves like PLAY, so it is folded into PLAY before it is latched.
    assign w_mode_norm = (mode == 2'b11) ? MODE_PLAY : mode;
    assign w_vs_rise   = vs_in && !r_vs_prev;

    // Latch the mode and advance or restart the blink counter on each vsync rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_prev   <= 1'b0;
            r_frame_cnt <= '0;
            r_mode_lat  <= MODE_PLAY;
        end else begin
            r_vs_prev <= vs_in;
            if (w_vs_rise) begin
                r_mode_lat <= w_mode_norm;
                // A mode change restarts the counter, so a new mode always starts in phase 0.
                if (w_mode_norm != r_mode_lat) begin
                    r_frame_cnt <= '0;
                end else begin
                    r_frame_cnt <= r_frame_cnt + BLINK_LOG2'(1);
                end
            end
        end
    end

    // Stage 0 -> 1: register the pixel classification and the sync signals.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active_p1 <= 1'b0;
            r_apple_p1  <= 1'b0;
            r_corner_p1 <= 1'b0;
            r_code_p1   <= 2'b00;
            r_de_p1     <= 1'b0;
            r_hs_p1     <= 1'b0;
            r_vs_p1     <= 1'b0;
        end else begin
            r_active_p1 <= w_active_p0;
            r_apple_p1  <= w_apple_p0;
            r_corner_p1 <= w_corner_p0;
            r_code_p1   <= snake;
            r_de_p1     <= de_in;
            r_hs_p1     <= hs_in;
            r_vs_p1     <= vs_in;
        end
    end

    assign w_phase = r_frame_cnt[BLINK_LOG2-1];
    assign w_pause = (r_mode_lat == MODE_PAUSE);
    assign w_over  = (r_mode_lat == MODE_OVER);
    assign w_play  = !w_pause && !w_over;

    // Choose the pixel colour by priority, then dim the whole picture in pause.
    always_comb begin
        w_rgb_p1 = BG_COLOR;
        if (!r_active_p1) begin
            w_rgb_p1 = 24'h000000;
        end else if (r_apple_p1 && !w_over) begin
            // On game over the apple is hidden and its cell falls through to the cell code below.
            if (r_corner_p1) begin
                w_rgb_p1 = BG_COLOR;
            end else if (w_play && w_phase) begin
                w_rgb_p1 = f_half(APPLE_COLOR);
            end else begin
                w_rgb_p1 = APPLE_COLOR;
            end
        end else begin
            case (r_code_p1)
                CODE_WALL: w_rgb_p1 = WALL_COLOR;
                CODE_HEAD, CODE_BODY: begin
                    if (r_corner_p1) begin
                        w_rgb_p1 = BG_COLOR;
                    end else if (w_over && w_phase) begin
                        w_rgb_p1 = OVER_COLOR;
                    end else if (r_code_p1 == CODE_HEAD) begin
                        w_rgb_p1 = HEAD_COLOR;
                    end else begin
                        w_rgb_p1 = BODY_COLOR;
                    end
                end
                default:   w_rgb_p1 = BG_COLOR;
            endcase
        end
        if (w_pause) begin
            w_rgb_p1 = f_half(w_rgb_p1);
        end
    end

    // Stage 1 -> 2: register the colour and the aligned sync signals onto the output pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_rgb <= 24'h000000;
            de_out  <= 1'b0;
            hs_out  <= 1'b0;
            vs_out  <= 1'b0;
        end else begin
            vga_rgb <= w_rgb_p1;
            de_out  <= r_de_p1;
            hs_out  <= r_hs_p1;
            vs_out  <= r_vs_p1;
        end
    end

endmodule

// File: tb/tb_snake_vga_renderer.sv
// Scoreboard bench for snake_vga_renderer. The reference model applies the
// colouring rules to plain integer coordinates.
module tb_snake_vga_renderer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] x_pos = '0;
    logic [11:0] y_pos = '0;
    logic        de_in = 1'b0;
    logic        hs_in = 1'b0;
    logic        vs_in = 1'b0;
    logic [1:0]  snake = '0;
    logic [5:0]  apple_x = 6'd3;
    logic [4:0]  apple_y = 5'd2;
    logic [1:0]  mode = '0;
    logic [23:0] vga_rgb;
    logic        de_out;
    logic        hs_out;
    logic        vs_out;

    always #5 clk = ~clk;

    snake_vga_renderer dut (
        .clk     (clk),
        .rst     (rst),
        .x_pos   (x_pos),
        .y_pos   (y_pos),
        .de_in   (de_in),
        .hs_in   (hs_in),
        .vs_in   (vs_in),
        .snake   (snake),
        .apple_x (apple_x),
        .apple_y (apple_y),
        .mode    (mode),
        .vga_rgb (vga_rgb),
        .de_out  (de_out),
        .hs_out  (hs_out),
        .vs_out  (vs_out)
    );

    typedef struct {
        int unsigned edge_i;
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
        bit          has_c;
        logic [23:0] cval;
        string       name;
    } exp_t;

    exp_t        q[$];
    int unsigned edges = 0;
    int          checks = 0;
    int          errors = 0;

    // Reference frame state
    int          m_fc = 0;
    int          m_ml = 0;
    bit          m_vsp = 1'b0;
    logic [1:0]  nxt_mode = 2'b00;
    logic [5:0]  nxt_ax = 6'd3;
    logic [4:0]  nxt_ay = 5'd2;

    always @(posedge clk) edges <= edges + 1;

    function automatic logic [23:0] dim(input logic [23:0] c);
        int r, g, b;
        r = int'(c[23:16]) / 2;
        g = int'(c[15:8]) / 2;
        b = int'(c[7:0]) / 2;
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    function automatic logic [23:0] ref_color(input int x, input int y, input int s,
                                              input int ax, input int ay, input int md, input int fc);
        int          phase;
        bit          apple, corner;
        logic [23:0] c;
        if (x >= 480 || y >= 272) return 24'h000000;
        phase  = (fc / 8) % 2;
        apple  = ((x / 16) % 64 == ax) && ((y / 16) % 32 == ay);
        corner = (x % 16 == 0) && (y % 16 == 0);
        if (apple && md != 2) begin
            if (corner) c = 24'h000000;
            else if (md == 0 && phase == 1) c = dim(24'hFF0000);
            else c = 24'hFF0000;
        end else if (s == 3) begin
            c = 24'hFF0000;
        end else if (s == 1 || s == 2) begin
            if (corner) c = 24'h000000;
            else if (md == 2 && phase == 1) c = 24'hFFFFFF;
            else c = (s == 1) ? 24'h0000FF : 24'hFFFF00;
        end else begin
            c = 24'h000000;
        end
        if (md == 1) c = dim(c);
        return c;
    endfunction

    // Advance the model frame state with the current sample, then queue its expected output.
    task automatic push_exp(input string nm, input bit hc, input logic [23:0] cv);
        exp_t e;
        if (vs_in && !m_vsp) begin
            if (int'(mode) != m_ml) m_fc = 0;
            else m_fc = (m_fc + 1) % 16;
            m_ml = int'(mode);
        end
        m_vsp    = vs_in;
        e.edge_i = edges + 1;
        e.rgb    = ref_color(int'(x_pos), int'(y_pos), int'(snake), int'(apple_x), int'(apple_y), m_ml, m_fc);
        e.de     = de_in;
        e.hs     = hs_in;
        e.vs     = vs_in;
        e.has_c  = hc;
        e.cval   = cv;
        e.name   = nm;
        q.push_back(e);
    endtask

    task automatic step(input int x, input int y, input int s, input bit de, input bit hs, input bit vs,
                        input string nm = "rand", input bit hc = 1'b0, input logic [23:0] cv = 24'h0);
        @(negedge clk);
        x_pos   = 12'(x);
        y_pos   = 12'(y);
        snake   = 2'(s);
        de_in   = de;
        hs_in   = hs;
        vs_in   = vs;
        mode    = nxt_mode;
        apple_x = nxt_ax;
        apple_y = nxt_ay;
        push_exp(nm, hc, cv);
    endtask

    task automatic pix(input int x, input int y, input int s, input string nm, input logic [23:0] cv);
        step(x, y, s, 1'b1, 1'b0, 1'b0, nm, 1'b1, cv);
    endtask

    task automatic vs_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            step(500, 300, 0, 1'b0, 1'b0, 1'b1);
            step(500, 300, 0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #3 rst = 1'b1;
        repeat (n) @(negedge clk);
        #3 rst = 1'b0;
        m_fc  = 0;
        m_ml  = 0;
        m_vsp = 1'b0;
        push_exp("post_reset", 1'b0, 24'h0);
        @(negedge clk);
        #2;
        checks++;
        if (de_out !== 1'b0) begin
            errors++;
            $display("FAIL de_not_early: de_out=%b, expected 0 one clock after release", de_out);
        end
        push_exp("post_reset2", 1'b0, 24'h0);
    endtask

    // Monitor: checks zeros during reset, otherwise pops each due entry and compares.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or posedge rst);
            #1;
            if (rst) begin
                q.delete();
                checks++;
                if (vga_rgb !== 24'h0 || de_out !== 1'b0 || hs_out !== 1'b0 || vs_out !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_out: rgb=%h de=%b hs=%b vs=%b, expected all 0",
                             vga_rgb, de_out, hs_out, vs_out);
                end
            end else begin
                while (q.size() > 0 && q[0].edge_i + 1 <= edges) begin
                    e = q.pop_front();
                    checks++;
                    if (e.edge_i + 1 != edges) begin
                        errors++;
                        $display("FAIL %s: entry for edge %0d not checked in time (now %0d)", e.name, e.edge_i, edges);
                    end else if (vga_rgb !== e.rgb || de_out !== e.de || hs_out !== e.hs || vs_out !== e.vs) begin
                        errors++;
                        $display("FAIL %s: got rgb=%h de=%b hs=%b vs=%b, expected rgb=%h de=%b hs=%b vs=%b",
                                 e.name, vga_rgb, de_out, hs_out, vs_out, e.rgb, e.de, e.hs, e.vs);
                    end
                    if (e.has_c) begin
                        checks++;
                        if (vga_rgb !== e.cval) begin
                            errors++;
                            $display("FAIL %s_const: got rgb=%h, expected %h", e.name, vga_rgb, e.cval);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #3 rst = 1'b0;
        push_exp("first", 1'b0, 24'h0);

        // PLAY colours, frame 0
        pix(17, 33, 1, "play_head", 24'h0000FF);
        pix(16, 32, 1, "play_head_corner", 24'h000000);
        pix(0, 0, 3, "play_wall_corner", 24'hFF0000);
        pix(480, 10, 1, "x_edge", 24'h000000);
        pix(10, 272, 2, "y_edge", 24'h000000);
        pix(479, 271, 2, "last_pixel", 24'hFFFF00);
        pix(48, 32, 0, "apple_corner", 24'h000000);
        pix(50, 40, 0, "apple_ph0", 24'hFF0000);

        // Apple pulse
        vs_pulses(8);
        pix(50, 40, 1, "apple_ph1", 24'h7F0000);
        pix(17, 33, 1, "head_ph1", 24'h0000FF);
        vs_pulses(8);
        pix(50, 40, 0, "apple_ph0_again", 24'hFF0000);

        // Out-of-grid apple index never matches
        nxt_ax = 6'd40;
        pix(640 % 480, 40, 0, "apple_far", 24'h000000);
        nxt_ax = 6'd3;

        // PAUSE is latched only at the next vsync rising edge
        nxt_mode = 2'b01;
        pix(100, 100, 2, "body_prelatch", 24'hFFFF00);
        vs_pulses(1);
        pix(100, 100, 2, "body_pause", 24'h7F7F00);
        pix(5, 5, 3, "wall_pause", 24'h7F0000);
        vs_pulses(8);
        pix(50, 40, 0, "apple_pause_ph1", 24'h7F0000);

        // OVER flash, starting in phase 0
        nxt_mode = 2'b10;
        vs_pulses(1);
        pix(17, 33, 1, "over_head_f0", 24'h0000FF);
        pix(50, 40, 0, "over_apple_hidden", 24'h000000);
        pix(50, 40, 2, "over_apple_body", 24'hFFFF00);
        vs_pulses(7);
        pix(17, 33, 1, "over_head_f7", 24'h0000FF);
        vs_pulses(1);
        pix(17, 33, 1, "over_head_f8", 24'hFFFFFF);
        pix(100, 100, 2, "over_body_f8", 24'hFFFFFF);
        pix(16, 32, 1, "over_corner", 24'h000000);
        pix(0, 16, 3, "over_wall", 24'hFF0000);

        nxt_mode = 2'b00;
        vs_pulses(1);

        // Reset mid-line with the outputs active
        for (int i = 0; i < 4; i++) step(20 + i, 20, 1, 1'b1, 1'b1, 1'b0);
        do_reset(3);

        // Random stream
        for (int i = 0; i < 1500; i++) begin
            int x, y;
            if ($urandom_range(0, 99) == 0) nxt_mode = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 49) == 0) begin
                nxt_ax = 6'($urandom_range(0, 31));
                nxt_ay = 5'($urandom_range(0, 18));
            end
            if ($urandom_range(0, 1) == 1) begin
                x = int'(nxt_ax) * 16 + int'($urandom_range(0, 15));
                y = int'(nxt_ay) * 16 + int'($urandom_range(0, 15));
            end else begin
                x = int'($urandom_range(0, 520));
                y = int'($urandom_range(0, 300));
            end
            if ($urandom_range(0, 3) == 0) begin
                x = x & ~15;
                y = y & ~15;
            end
            step(x, y, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0));
        end

        repeat (4) @(negedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected outputs never appeared, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snake_vga_renderer.md
Name: snake_vga_renderer

Overview:
- Parametrised successor to the snake pixel colouriser; sits between the VGA timing generator / snake grid map and the RGB output pins.
- Classifies each scanned pixel (apple, head, body, wall, empty) from its cell code and coordinates, then colours it.
- Adds a frame counter for apple pulsing and game-over flashing, a pause dim mode latched at frame boundaries, and a fixed 2-cycle pipeline with matched sync/DE delay.

Parameters:
- H_ACTIVE, 480, active pixels per line.
- V_ACTIVE, 272, active lines per frame.
- CELL_LOG2, 4, log2 of cell edge in pixels (cell = 16x16).
- GRID_X_W, 6, width of apple_x / cell column index.
- GRID_Y_W, 5, width of apple_y / cell row index.
- BLINK_LOG2, 4, phase bit = frame_cnt[BLINK_LOG2-1]; phase toggles every 2^(BLINK_LOG2-1) frames.
- HEAD_COLOR, 24'h0000FF, head colour.
- BODY_COLOR, 24'hFFFF00, body colour.
- WALL_COLOR, 24'hFF0000, wall colour.
- APPLE_COLOR, 24'hFF0000, apple colour.
- BG_COLOR, 24'h000000, empty-cell colour in the active area.
- OVER_COLOR, 24'hFFFFFF, game-over flash colour.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-high.
- x_pos  in  12  current pixel column.
- y_pos  in  12  current pixel row.
- de_in  in  1  data enable from the timing generator.
- hs_in  in  1  hsync from the timing generator.
- vs_in  in  1  vsync from the timing generator, active-high.
- snake  in  2  cell code for (x_pos, y_pos), same cycle: 00 NONE, 01 HEAD, 10 BODY, 11 WALL.
- apple_x  in  GRID_X_W  apple cell column.
- apple_y  in  GRID_Y_W  apple cell row.
- mode  in  2  00 PLAY, 01 PAUSE, 10 OVER, 11 reserved (treated as PLAY).
- vga_rgb  out  24  pixel colour.
- de_out  out  1  de_in delayed 2 cycles.
- hs_out  out  1  hs_in delayed 2 cycles.
- vs_out  out  1  vs_in delayed 2 cycles.

Behaviour:
- Reset (async, rst=1):
  - vga_rgb, de_out, hs_out and vs_out clear to 0.
  - Pipeline registers clear; frame_cnt clears to 0; vs_prev clears to 0; mode_lat = PLAY.
  - Reset asserted mid-frame drops output immediately; the first valid pixel appears 2 clocks after release.
- Latency: exactly 2 clocks from inputs to vga_rgb; the de/hs/vs delay lines match, so all outputs stay aligned.
- Stage 1 (registered):
  - active = x_pos<H_ACTIVE && y_pos<V_ACTIVE.
  - is_apple = (x_pos>>CELL_LOG2)[GRID_X_W-1:0]==apple_x && (y_pos>>CELL_LOG2)[GRID_Y_W-1:0]==apple_y.
  - corner = x_pos[CELL_LOG2-1:0]==0 && y_pos[CELL_LOG2-1:0]==0.
  - The cell code is also registered here.
- Stage 2 colour priority (registered):
  1. !active -> 24'h000000.
  2. Apple.
  3. WALL.
  4. HEAD / BODY.
  5. NONE -> BG_COLOR.
- Corner pixel of an apple, head or body cell -> BG_COLOR (grid dot). Wall cells are solid.
- Frame counter:
  - vs rising edge = vs_in==1 && vs_prev==0.
  - On each rising edge: mode_lat<=mode; frame_cnt increments, wrapping at 2^BLINK_LOG2.
  - If the new mode differs from mode_lat, frame_cnt<=0 instead, so OVER always starts in phase 0.
  - A mode change mid-frame has no visible effect until the next vs rising edge (no tearing).
- PLAY:
  - Normal colours.
  - Apple = APPLE_COLOR when phase=0; each 8-bit channel >>1 when phase=1 (pulse).
- PAUSE:
  - Every non-black output has each channel >>1.
  - Apple does not pulse (phase ignored).
- OVER:
  - Apple cells render as the underlying cell code (apple hidden).
  - HEAD/BODY pixels, corners excluded, = OVER_COLOR when phase=1, normal colour when phase=0.
  - WALL unchanged.
- Apple index is truncated compare; apple_x beyond the visible grid simply never matches.
- Coordinates ≥ H_ACTIVE/V_ACTIVE are black regardless of snake/apple.

Test Plan:
- Reset: hold rst for 3 clocks mid-line -> vga_rgb=0, de/hs/vs_out=0. Release with de_in=1 -> de_out rises exactly 2 clocks later.
- PLAY colours: frame_cnt=0, snake=01, x=17, y=33 -> 24'h0000FF after 2 clocks. Same cell at x=16, y=32 (corner) -> 24'h000000. snake=11 at x=0, y=0 -> 24'hFF0000. x=480, snake=01 -> 0.
- Apple pulse: apple_x=3, apple_y=2, x=50, y=40, mode=PLAY. Phase 0 -> FF0000. After 8 vs rising edges (phase 1) -> 7F0000. After 16 edges -> FF0000 again.
- PAUSE latch: switch mode to 01 mid-frame -> body pixel stays FFFF00 until the next vs rising edge, then becomes 7F7F00. Wall becomes 7F0000.
- OVER flash: mode=10 latched, frame_cnt cleared to 0 -> head shows 0000FF for frames 0-7, FFFFFF for frames 8-15. Apple cell with snake=00 -> 000000.
- Pipeline alignment: random x/y/snake/hs/vs stream -> each vga_rgb equals the model colour of the inputs 2 clocks earlier, and hs_out/vs_out equal hs_in/vs_in delayed 2.
